regfile_bypassed: RTL and testbench

- Next-generation physical register file for the int and fp issue stages.
- Multi-ported storage, bank-interleaved by address; per-port enable and 1-cycle registered read.
- Same-cycle write-to-read bypass and optional hardwired zero register.
- Self-clearing init state machine with a ready flag, plus sticky write-collision detection for debug.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_bank.sv | 45 ++++
 rtl/regfile_bypassed.sv | 176 +++++++++++++++++
 tb/tb_regfile_bypassed.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and address helpers for the bypassed register file.
//   rf_state_t    : CLEAR (rows being zeroed) / RUN (normal operation)
//   rf_addr_width : address width for a given register count
//   rf_bank_of    : bank that holds a physical register (addr % bank_num)
//   rf_row_of     : row inside that bank (addr / bank_num)
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DEFAULT_PREG_SIZE = 128;
  localparam int RF_DEFAULT_ADDR_W    = $clog2(RF_DEFAULT_PREG_SIZE);

  function automatic int rf_addr_width(input int preg_size);
    return (preg_size > 1) ? $clog2(preg_size) : 1;
  endfunction

  function automatic int rf_bank_of(input int addr, input int bank_num);
    return addr % bank_num;
  endfunction

  function automatic int rf_row_of(input int addr, input int bank_num);
    return addr / bank_num;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: one address-interleaved bank of the register file.
//   clk           : clock
//   clr, clr_row  : zero one row this cycle (overrides all write ports)
//   we/wrow/wdata : WRITE_PORT write ports, highest index wins on equal rows
//   rrow/rdata    : READ_PORT asynchronous read ports (registered in the top)
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int ROWS       = 64,
  parameter int ROW_W      = 6,
  parameter int DATA_WIDTH = 64,
  parameter int READ_PORT  = 4,
  parameter int WRITE_PORT = 4
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic [ROW_W-1:0]                 clr_row,
  input  logic [WRITE_PORT-1:0]            we,
  input  logic [WRITE_PORT*ROW_W-1:0]      wrow,
  input  logic [WRITE_PORT*DATA_WIDTH-1:0] wdata,
  input  logic [READ_PORT*ROW_W-1:0]       rrow,
  output logic [READ_PORT*DATA_WIDTH-1:0]  rdata
);

  logic [DATA_WIDTH-1:0] mem [ROWS];

  // Later loop iterations override earlier ones, so the highest-index port
  // wins when several ports target the same row.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem[clr_row] <= '0;
    end else begin
      for (int j = 0; j < WRITE_PORT; j++) begin
        if (we[j]) begin
          mem[wrow[j*ROW_W +: ROW_W]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORT; gi++) begin : g_rd
    assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = mem[rrow[gi*ROW_W +: ROW_W]];
  end

endmodule

// File: rtl/regfile_bypassed.sv
// regfile_bypassed: multi-ported, bank-interleaved physical register file with
// write-to-read bypass, optional hardwired zero register, self-clearing init
// and sticky write-collision flag.
//   clk, rst      : clock, asynchronous active-high reset
//   rst_sync      : synchronous request to re-run the clear
//   en/raddr      : per-port read enable and address
//   rdata         : read data, registered (valid the cycle after en)
//   we/waddr/wdata: write ports
//   ready         : clear finished, regfile usable
//   wcollide      : sticky, two write ports hit the same address in one cycle
module regfile_bypassed
  import regfile_pkg::*;
#(
  parameter int READ_PORT  = 4,
  parameter int WRITE_PORT = 4,
  parameter int PREG_SIZE  = 128,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_NUM   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              rst_sync,
  input  logic [READ_PORT-1:0]                              en,
  input  logic [READ_PORT*rf_addr_width(PREG_SIZE)-1:0]     raddr,
  output logic [READ_PORT*DATA_WIDTH-1:0]                   rdata,
  input  logic [WRITE_PORT-1:0]                             we,
  input  logic [WRITE_PORT*rf_addr_width(PREG_SIZE)-1:0]    waddr,
  input  logic [WRITE_PORT*DATA_WIDTH-1:0]                  wdata,
  output logic                                              ready,
  output logic                                              wcollide
);

  localparam int AW     = rf_addr_width(PREG_SIZE);
  localparam int ROWS   = PREG_SIZE / BANK_NUM;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam int DW     = DATA_WIDTH;

  rf_state_t              state, state_next;
  logic [ROW_W-1:0]       cnt, cnt_next;
  logic                   wcollide_next;
  logic                   collide;
  logic [READ_PORT*DW-1:0] rd_next;

  logic [WRITE_PORT-1:0]        wvalid;
  logic [BANK_W-1:0]            wbank [WRITE_PORT];
  logic [WRITE_PORT*ROW_W-1:0]  wrow;
  logic [BANK_W-1:0]            rbank [READ_PORT];
  logic [READ_PORT*ROW_W-1:0]   rrow;
  logic [WRITE_PORT-1:0]        bank_we    [BANK_NUM];
  logic [READ_PORT*DW-1:0]      bank_rdata [BANK_NUM];

  // Address decode. Writes are only live in RUN, and writes to preg 0 are
  // dropped here so they touch neither storage, bypass nor collision logic.
  for (genvar gi = 0; gi < WRITE_PORT; gi++) begin : g_wdec
    assign wbank[gi] = BANK_W'(rf_bank_of(int'(waddr[gi*AW +: AW]), BANK_NUM));
    assign wrow[gi*ROW_W +: ROW_W] = ROW_W'(rf_row_of(int'(waddr[gi*AW +: AW]), BANK_NUM));
    assign wvalid[gi] = we[gi] && (state == RUN) &&
                        !((ZERO_REG != 0) && (waddr[gi*AW +: AW] == '0));
  end

  for (genvar gi = 0; gi < READ_PORT; gi++) begin : g_rdec
    assign rbank[gi] = BANK_W'(rf_bank_of(int'(raddr[gi*AW +: AW]), BANK_NUM));
    assign rrow[gi*ROW_W +: ROW_W] = ROW_W'(rf_row_of(int'(raddr[gi*AW +: AW]), BANK_NUM));
  end

  always_comb begin
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int j = 0; j < WRITE_PORT; j++) begin
        bank_we[b][j] = wvalid[j] && (int'(wbank[j]) == b);
      end
    end
  end

  for (genvar gi = 0; gi < BANK_NUM; gi++) begin : g_bank
    regfile_bank #(
      .ROWS       (ROWS),
      .ROW_W      (ROW_W),
      .DATA_WIDTH (DW),
      .READ_PORT  (READ_PORT),
      .WRITE_PORT (WRITE_PORT)
    ) u_bank (
      .clk     (clk),
      .clr     (state == CLEAR),
      .clr_row (cnt),
      .we      (bank_we[gi]),
      .wrow    (wrow),
      .wdata   (wdata),
      .rrow    (rrow),
      .rdata   (bank_rdata[gi])
    );
  end

  // Read data selection: stored value, then bypass (ascending loop so the
  // highest-index writer wins), then the zero-register / clearing override.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < READ_PORT; i++) begin
      rd_next[i*DW +: DW] = bank_rdata[rbank[i]][i*DW +: DW];
      if (BYPASS != 0) begin
        for (int j = 0; j < WRITE_PORT; j++) begin
          if (wvalid[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
            rd_next[i*DW +: DW] = wdata[j*DW +: DW];
          end
        end
      end
      if (((ZERO_REG != 0) && (raddr[i*AW +: AW] == '0)) || (state == CLEAR)) begin
        rd_next[i*DW +: DW] = '0;
      end
    end
  end

  // Pairwise compare of live write addresses.
  always_comb begin
    collide = 1'b0;
    for (int j = 0; j < WRITE_PORT; j++) begin
      for (int k = j + 1; k < WRITE_PORT; k++) begin
        if (wvalid[j] && wvalid[k] && (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
          collide = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    wcollide_next = wcollide;
    case (state)
      CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_ROW) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (collide) wcollide_next = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
    if (rst_sync) begin
      state_next    = CLEAR;
      cnt_next      = '0;
      wcollide_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      cnt      <= '0;
      wcollide <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      wcollide <= wcollide_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < READ_PORT; i++) begin
        if (en[i]) rdata[i*DW +: DW] <= rd_next[i*DW +: DW];
      end
    end
  end

  assign ready = (state == RUN);

endmodule

// File: tb/tb_regfile_bypassed.sv
// tb_regfile_bypassed: directed, table-driven bench for regfile_bypassed.
// Two instances share all inputs: u_dut (BYPASS=1) and u_dut_nb (BYPASS=0).
module tb_regfile_bypassed;
  localparam int RP = 4, WP = 4, PS = 128, DW = 64, AW = 7;

  logic            clk = 1'b0;
  logic            rst, rst_sync;
  logic [RP-1:0]   en;
  logic [RP*AW-1:0] raddr;
  logic [RP*DW-1:0] rdata, rdata_nb;
  logic [WP-1:0]   we;
  logic [WP*AW-1:0] waddr;
  logic [WP*DW-1:0] wdata;
  logic            ready, ready_nb, wcollide, wcollide_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_bypassed #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rst_sync(rst_sync), .en(en), .raddr(raddr),
    .rdata(rdata), .we(we), .waddr(waddr), .wdata(wdata),
    .ready(ready), .wcollide(wcollide)
  );

  regfile_bypassed #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rst_sync(rst_sync), .en(en), .raddr(raddr),
    .rdata(rdata_nb), .we(we), .waddr(waddr), .wdata(wdata),
    .ready(ready_nb), .wcollide(wcollide_nb)
  );

  typedef struct {
    logic        wv;
    int          wp;
    int          wa;
    logic [63:0] wd;
    logic        rv;
    int          rp;
    int          ra;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en       = '0;
    we       = '0;
    rst_sync = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [63:0] d);
    we[p]              = 1'b1;
    waddr[p*AW +: AW]  = AW'(a);
    wdata[p*DW +: DW]  = d;
  endtask

  task automatic rd(input int p, input int a);
    en[p]             = 1'b1;
    raddr[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [63:0] port(input logic [RP*DW-1:0] v, input int p);
    return v[p*DW +: DW];
  endfunction

  // Bounded wait: the count of edges until ready must equal exp.
  task automatic wait_ready(input string name, input int exp);
    int n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(n), 64'(exp));
  endtask

  task automatic sweep_zero(input string name);
    for (int g = 0; g < PS / RP; g++) begin
      idle();
      for (int p = 0; p < RP; p++) rd(p, g * RP + p);
      tick();
      for (int p = 0; p < RP; p++) begin
        check($sformatf("%s[%0d]", name, g * RP + p), port(rdata, p), 64'h0);
      end
    end
    idle();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 0, 5,   64'hDEAD,             1'b0, 0, 0,   64'h0};
    vecs[1]  = '{1'b0, 0, 0,   64'h0,                1'b1, 2, 5,   64'hDEAD};
    vecs[2]  = '{1'b1, 0, 5,   64'h1,                1'b0, 2, 0,   64'hDEAD};
    vecs[3]  = '{1'b0, 0, 0,   64'h0,                1'b1, 2, 5,   64'h1};
    vecs[4]  = '{1'b1, 1, 9,   64'hAA,               1'b1, 3, 9,   64'hAA};
    vecs[5]  = '{1'b0, 0, 0,   64'h0,                1'b1, 0, 9,   64'hAA};
    vecs[6]  = '{1'b1, 2, 0,   64'hFFFF,             1'b1, 1, 0,   64'h0};
    vecs[7]  = '{1'b1, 3, 127, 64'h123456789ABCDEF0, 1'b1, 0, 127, 64'h123456789ABCDEF0};
    vecs[8]  = '{1'b0, 0, 0,   64'h0,                1'b1, 1, 127, 64'h123456789ABCDEF0};
    vecs[9]  = '{1'b1, 0, 126, 64'hFFFFFFFFFFFFFFFF, 1'b1, 2, 126, 64'hFFFFFFFFFFFFFFFF};
    vecs[10] = '{1'b0, 0, 0,   64'h0,                1'b1, 3, 1,   64'h0};
    vecs[11] = '{1'b0, 0, 0,   64'h0,                1'b1, 2, 9,   64'hAA};

    idle();
    raddr = '0;
    waddr = '0;
    wdata = '0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_rdata",       64'(|rdata),       64'h0);
    check("rst_ready",       64'(ready),        64'h0);
    check("rst_wcollide",    64'(wcollide),     64'h0);
    check("rst_ready_nb",    64'(ready_nb),     64'h0);

    // Initial clear length and contents
    rst = 1'b0;
    wait_ready("clear_len", 64);
    check("ready_nb_after_clear", 64'(ready_nb), 64'h1);
    sweep_zero("init_zero");

    // Table-driven single-cycle vectors
    for (int v = 0; v < 12; v++) begin
      idle();
      if (vecs[v].wv) wr(vecs[v].wp, vecs[v].wa, vecs[v].wd);
      if (vecs[v].rv) rd(vecs[v].rp, vecs[v].ra);
      tick();
      check($sformatf("vec%0d", v), port(rdata, vecs[v].rp), vecs[v].exp_rd);
    end
    idle();
    check("no_collide_after_table", 64'(wcollide), 64'h0);

    // Same-cycle write/read: write-first vs read-first
    wr(1, 20, 64'hAA);
    rd(0, 20);
    tick();
    check("bypass_on",   port(rdata, 0),    64'hAA);
    check("bypass_off",  port(rdata_nb, 0), 64'h0);
    idle();
    rd(0, 20);
    tick();
    check("bypass_off_reread", port(rdata_nb, 0), 64'hAA);

    // Dual write to preg 0 is dropped: no collision, reads 0
    idle();
    wr(1, 0, 64'h11);
    wr(3, 0, 64'h33);
    rd(2, 0);
    tick();
    check("zero_no_collide", 64'(wcollide), 64'h0);
    check("zero_read",       port(rdata, 2), 64'h0);

    // Dual write to preg 12: highest port wins, wcollide sticky
    idle();
    wr(1, 12, 64'h11);
    wr(3, 12, 64'h33);
    rd(0, 12);
    tick();
    check("collide_set",     64'(wcollide),    64'h1);
    check("collide_set_nb",  64'(wcollide_nb), 64'h1);
    check("collide_bypass",  port(rdata, 0),   64'h33);
    idle();
    rd(1, 12);
    tick();
    check("collide_store",    port(rdata, 1),    64'h33);
    check("collide_store_nb", port(rdata_nb, 1), 64'h33);
    check("collide_sticky",   64'(wcollide),     64'h1);

    // rst_sync re-clear; writes during clear are lost
    idle();
    wr(0, 40, 64'h77);
    tick();
    idle();
    rst_sync = 1'b1;
    rd(0, 127);
    tick();
    check("resync_ready",    64'(ready),      64'h0);
    check("resync_wcollide", 64'(wcollide),   64'h0);
    check("resync_last_run_read", port(rdata, 0), 64'h123456789ABCDEF0);
    idle();
    wr(0, 40, 64'h55);
    rd(0, 5);
    tick();
    check("clear_read_zero", port(rdata, 0), 64'h0);
    idle();
    wait_ready("resync_len", 63);
    sweep_zero("resync_zero");

    // Asynchronous rst mid-clear at cnt = 30
    idle();
    wr(0, 127, 64'hABC);
    tick();
    idle();
    rd(0, 127);
    tick();
    check("pre_rst_read", port(rdata, 0), 64'hABC);
    idle();
    rst_sync = 1'b1;
    tick();
    rst_sync = 1'b0;
    repeat (30) tick();
    check("hold_in_clear", port(rdata, 0), 64'hABC);
    #2;
    rst = 1'b1;
    #1;
    check("async_rdata", port(rdata, 0), 64'h0);
    check("async_ready", 64'(ready),     64'h0);
    tick();
    tick();
    rst = 1'b0;
    wait_ready("restart_len", 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
